// File: rtl/rf_wb_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler_pkg
//   Shared constants and types for the register-file writeback scheduler.
//   - REG_ZERO      : index of the hard-wired zero register (x0)
//   - XLEN, REG_AW  : default data width and register index width
//   - WB_EXU/WB_LSU : requester index of each writeback port
//   - prio_e        : round-robin priority pointer encoding
// -----------------------------------------------------------------------------
package rf_wb_scheduler_pkg;

    localparam int REG_ZERO = 0;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;

    localparam int WB_EXU   = 0;
    localparam int WB_LSU   = 1;

    // Which port wins the next contended cycle.
    typedef enum logic {
        PRIO_EXU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

endpackage : rf_wb_scheduler_pkg

// File: rtl/rf_wb_scheduler_if.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler_if
//   Bundles every non-clock signal of the writeback scheduler.
//   - issue_*   : decode issue handshake (destination register reservation)
//   - req0_*    : EXU writeback request
//   - req1_*    : LSU writeback request
//   - rf_*      : register-file write port
//   - chk_*     : decode source-register busy lookups
//   - busy_vec  : raw scoreboard contents
//   Modports:
//   - master : the surroundings (decode, EXU, LSU, register file)
//   - slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface rf_wb_scheduler_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);

    logic                     issue_valid;
    logic [ADDR_WIDTH-1:0]    issue_rd;
    logic                     issue_ready;

    logic                     req0_valid;
    logic [ADDR_WIDTH-1:0]    req0_waddr;
    logic [DATA_WIDTH-1:0]    req0_wdata;
    logic                     req0_ready;

    logic                     req1_valid;
    logic [ADDR_WIDTH-1:0]    req1_waddr;
    logic [DATA_WIDTH-1:0]    req1_wdata;
    logic                     req1_ready;

    logic                     rf_wen;
    logic [ADDR_WIDTH-1:0]    rf_waddr;
    logic [DATA_WIDTH-1:0]    rf_wdata;

    logic [ADDR_WIDTH-1:0]    chk_raddr1;
    logic [ADDR_WIDTH-1:0]    chk_raddr2;
    logic                     chk_busy1;
    logic                     chk_busy2;

    logic [2**ADDR_WIDTH-1:0] busy_vec;

    modport master (
        output issue_valid, issue_rd,
        input  issue_ready,
        output req0_valid, req0_waddr, req0_wdata,
        input  req0_ready,
        output req1_valid, req1_waddr, req1_wdata,
        input  req1_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        output chk_raddr1, chk_raddr2,
        input  chk_busy1, chk_busy2,
        input  busy_vec
    );

    modport slave (
        input  issue_valid, issue_rd,
        output issue_ready,
        input  req0_valid, req0_waddr, req0_wdata,
        output req0_ready,
        input  req1_valid, req1_waddr, req1_wdata,
        output req1_ready,
        output rf_wen, rf_waddr, rf_wdata,
        input  chk_raddr1, chk_raddr2,
        output chk_busy1, chk_busy2,
        output busy_vec
    );

endinterface : rf_wb_scheduler_if

// File: rtl/rf_wb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rf_wb_rr_arb2
//   Two-way round-robin arbiter with a combinational one-hot grant.
//   The priority pointer only moves on contention, and then it moves to the
//   port that lost, so a lone requester never disturbs the fairness order.
//   Ports:
//   - clk, rst_n : clock, asynchronous active-low reset (pointer -> EXU)
//   - valid[1:0] : request per port (index WB_EXU / WB_LSU)
//   - grant[1:0] : one-hot grant, all-zero when nothing is requested
// -----------------------------------------------------------------------------
module rf_wb_rr_arb2
    import rf_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    prio_e prio_q;
    prio_e prio_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PRIO_EXU;
        end else begin
            prio_q <= prio_d;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        grant  = '0;
        prio_d = prio_q;
        unique case (valid)
            2'b01: grant[WB_EXU] = 1'b1;
            2'b10: grant[WB_LSU] = 1'b1;
            2'b11: begin
                if (prio_q == PRIO_EXU) begin
                    grant[WB_EXU] = 1'b1;
                    prio_d        = PRIO_LSU;
                end else begin
                    grant[WB_LSU] = 1'b1;
                    prio_d        = PRIO_EXU;
                end
            end
            default: ;
        endcase
    end

endmodule : rf_wb_rr_arb2

// File: rtl/rf_wb_scheduler.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler
//   Shares the single register-file write port between the EXU (port 0) and
//   the LSU (port 1), and keeps a scoreboard of destination registers with a
//   write still outstanding so decode can stall on RAW/WAW hazards.
//   Ports:
//   - clk, rst_n : clock, asynchronous active-low reset
//   - bus        : rf_wb_scheduler_if.slave (issue, req0, req1, rf write port,
//                  busy lookups, busy_vec)
//   Timing:
//   - grant/ready is combinational; the granted write reaches rf_* one cycle
//     after its handshake.
//   - A busy bit clears on the edge that ends the rf_wen cycle, so a RAW
//     consumer released by the clear finds its data already in the RF.
// -----------------------------------------------------------------------------
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_AW,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_wb_scheduler_if.slave   bus
);

    localparam int NREGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_ZERO);

    // ---------------------------------------------------------------- arbiter
    logic [1:0] valid;
    logic [1:0] grant;

    assign valid = {bus.req1_valid, bus.req0_valid};

    rf_wb_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .grant (grant)
    );

    assign bus.req0_ready = grant[WB_EXU];
    assign bus.req1_ready = grant[WB_LSU];

    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_waddr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // grant is already qualified by valid, so any grant bit is a handshake.
    assign hs = |grant;

    always_comb begin
        sel_waddr = bus.req0_waddr;
        sel_wdata = bus.req0_wdata;
        if (grant[WB_LSU]) begin
            sel_waddr = bus.req1_waddr;
            sel_wdata = bus.req1_wdata;
        end
    end

    // ------------------------------------------------------------ write stage
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            // Writes to x0 are accepted and dropped here.
            wen_q <= hs && (sel_waddr != X0);
            if (hs) begin
                waddr_q <= sel_waddr;
                wdata_q <= sel_wdata;
            end
        end
    end

    assign bus.rf_wen   = wen_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;

    // ------------------------------------------------------------- scoreboard
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             set_en;
    logic             clr_en;

    assign bus.issue_ready = !busy_q[bus.issue_rd];

    assign set_en = bus.issue_valid && bus.issue_ready && (bus.issue_rd != X0);
    assign clr_en = wen_q && (waddr_q != X0);

    // NOTE: blocking assignments inside always_comb act in order, so placing
    // the set after the clear makes set win on a same-index collision.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[waddr_q]     = 1'b0;
        if (set_en) busy_d[bus.issue_rd] = 1'b1;
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset as a
    // whole; this is what lets reset abandon every pending reservation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.chk_busy1 = (bus.chk_raddr1 != X0) && busy_q[bus.chk_raddr1];
    assign bus.chk_busy2 = (bus.chk_raddr2 != X0) && busy_q[bus.chk_raddr2];
    assign bus.busy_vec  = busy_q;

endmodule : rf_wb_scheduler

// File: tb/tb_rf_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_scheduler
//   Directed bench for rf_wb_scheduler: a table of per-cycle vectors with
//   hand-computed expectations, followed by a hand-written mid-operation
//   reset sequence.
// -----------------------------------------------------------------------------
module tb_rf_wb_scheduler;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk;
    logic rst_n;

    rf_wb_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rf_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // comb = {issue_ready, req0_ready, req1_ready, chk_busy1, chk_busy2},
    // sampled before the edge; the rest is sampled just after the edge.
    typedef struct {
        logic          iv;
        logic [AW-1:0] ird;
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [AW-1:0] c1;
        logic [AW-1:0] c2;
        logic [4:0]    comb;
        logic          wen;
        logic          cmp_wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [31:0]   busy;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic drive(input vec_t v);
        bus.issue_valid = v.iv;
        bus.issue_rd    = v.ird;
        bus.req0_valid  = v.v0;
        bus.req0_waddr  = v.a0;
        bus.req0_wdata  = v.d0;
        bus.req1_valid  = v.v1;
        bus.req1_waddr  = v.a1;
        bus.req1_wdata  = v.d1;
        bus.chk_raddr1  = v.c1;
        bus.chk_raddr2  = v.c2;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.req0_valid  = 1'b0;
        bus.req0_waddr  = '0;
        bus.req0_wdata  = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_waddr  = '0;
        bus.req1_wdata  = '0;
        bus.chk_raddr1  = '0;
        bus.chk_raddr2  = '0;
    endtask

    initial begin
        //          iv    ird    v0    a0      d0             v1    a1     d1          c1     c2     comb      wen   cmp   waddr  wdata          busy
        // single write to x5
        vecs[0]  = '{1'b1, 5'd5, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,      5'd5,  5'd0,  5'b10000, 1'b0, 1'b1, 5'd0,  32'h0,         32'h0000_0020};
        vecs[1]  = '{1'b0, 5'd0, 1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0,  32'h0,      5'd5,  5'd0,  5'b11010, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF,  32'h0000_0020};
        vecs[2]  = '{1'b0, 5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,      5'd5,  5'd0,  5'b10010, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF,  32'h0000_0000};
        vecs[3]  = '{1'b0, 5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,      5'd5,  5'd0,  5'b10000, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF,  32'h0000_0000};
        // contention: grants 0,1,0,1 with the loser holding its request
        vecs[4]  = '{1'b0, 5'd0, 1'b1, 5'd10, 32'hA0,        1'b1, 5'd11, 32'hB0,     5'd0,  5'd0,  5'b11000, 1'b1, 1'b1, 5'd10, 32'hA0,        32'h0000_0000};
        vecs[5]  = '{1'b0, 5'd0, 1'b1, 5'd12, 32'hA1,        1'b1, 5'd11, 32'hB0,     5'd0,  5'd0,  5'b10100, 1'b1, 1'b1, 5'd11, 32'hB0,        32'h0000_0000};
        vecs[6]  = '{1'b0, 5'd0, 1'b1, 5'd12, 32'hA1,        1'b1, 5'd13, 32'hB1,     5'd0,  5'd0,  5'b11000, 1'b1, 1'b1, 5'd12, 32'hA1,        32'h0000_0000};
        vecs[7]  = '{1'b0, 5'd0, 1'b1, 5'd14, 32'hA2,        1'b1, 5'd13, 32'hB1,     5'd0,  5'd0,  5'b10100, 1'b1, 1'b1, 5'd13, 32'hB1,        32'h0000_0000};
        // x0: issue rd=0 reserves nothing; LSU write to x0 accepted, no rf_wen
        vecs[8]  = '{1'b1, 5'd0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h55,     5'd0,  5'd0,  5'b10100, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_0000};
        // hazard on x7
        vecs[9]  = '{1'b1, 5'd7, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,      5'd7,  5'd5,  5'b10000, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_0080};
        vecs[10] = '{1'b1, 5'd7, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,      5'd7,  5'd0,  5'b00010, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0000_0080};
        vecs[11] = '{1'b1, 5'd9, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h77,     5'd7,  5'd9,  5'b10110, 1'b1, 1'b1, 5'd7,  32'h77,        32'h0000_0280};
        // clear x7 while setting x3, then clear x9 while setting x7
        vecs[12] = '{1'b1, 5'd3, 1'b1, 5'd9,  32'h99,        1'b0, 5'd0,  32'h0,      5'd7,  5'd9,  5'b11011, 1'b1, 1'b1, 5'd9,  32'h99,        32'h0000_0208};
        vecs[13] = '{1'b1, 5'd7, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,      5'd7,  5'd9,  5'b10001, 1'b0, 1'b1, 5'd9,  32'h99,        32'h0000_0088};
        vecs[14] = '{1'b0, 5'd0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,      5'd3,  5'd0,  5'b10010, 1'b0, 1'b1, 5'd9,  32'h99,        32'h0000_0088};

        idle();
        rst_n = 1'b0;
        #2;
        check("reset rf_wen",      64'(bus.rf_wen),      64'd0);
        check("reset rf_waddr",    64'(bus.rf_waddr),    64'd0);
        check("reset rf_wdata",    64'(bus.rf_wdata),    64'd0);
        check("reset busy_vec",    64'(bus.busy_vec),    64'd0);
        check("reset issue_ready", 64'(bus.issue_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Each vector starts 1 time unit after a rising edge.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #3;
            check($sformatf("v%0d comb {ir,r0,r1,b1,b2}", i),
                  64'({bus.issue_ready, bus.req0_ready, bus.req1_ready, bus.chk_busy1, bus.chk_busy2}),
                  64'(vecs[i].comb));
            @(posedge clk);
            #1;
            check($sformatf("v%0d rf_wen", i), 64'(bus.rf_wen), 64'(vecs[i].wen));
            if (vecs[i].cmp_wr) begin
                check($sformatf("v%0d rf_waddr", i), 64'(bus.rf_waddr), 64'(vecs[i].waddr));
                check($sformatf("v%0d rf_wdata", i), 64'(bus.rf_wdata), 64'(vecs[i].wdata));
            end
            check($sformatf("v%0d busy_vec", i), 64'(bus.busy_vec), 64'(vecs[i].busy));
        end

        // Mid-operation reset: contend once so the pointer moves to the LSU,
        // then reset while a second write is being granted.
        idle();
        bus.req0_valid = 1'b1; bus.req0_waddr = 5'd20; bus.req0_wdata = 32'hC0;
        bus.req1_valid = 1'b1; bus.req1_waddr = 5'd21; bus.req1_wdata = 32'hC1;
        #3;
        check("rst seq grant0", 64'({bus.req0_ready, bus.req1_ready}), 64'b10);
        @(posedge clk);
        #1;
        check("rst seq rf_wen before reset", 64'(bus.rf_wen), 64'd1);
        bus.req0_waddr = 5'd22; bus.req0_wdata = 32'hC2;
        #2;
        check("rst seq grant1", 64'({bus.req0_ready, bus.req1_ready}), 64'b01);
        rst_n = 1'b0;
        #1;
        check("rst async rf_wen",   64'(bus.rf_wen),   64'd0);
        check("rst async busy_vec", 64'(bus.busy_vec), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst contended grant", 64'({bus.req0_ready, bus.req1_ready}), 64'b10);
        @(posedge clk);
        #1;
        check("post-rst rf_wen",   64'(bus.rf_wen),   64'd1);
        check("post-rst rf_waddr", 64'(bus.rf_waddr), 64'd22);
        check("post-rst rf_wdata", 64'(bus.rf_wdata), 64'hC2);
        idle();
        @(posedge clk);
        #1;
        check("post-rst idle rf_wen", 64'(bus.rf_wen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rf_wb_scheduler
